// File: rtl/corr_data_rx.sv
// corr_data_rx: drives the divided serial clock, captures LSB-first words from corr_sdi and acknowledges each word
module corr_data_rx #(
  parameter int M          = 166667,
  parameter int DATA_LENG  = 32,
  parameter int DATA_TIMES = 2
) (
  input  logic        clki,
  input  logic        rst_n,
  input  logic        start,
  input  logic        corr_sdi,
  output logic        corr_sclk,
  output logic        rx_ack,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic [11:0] frame_cnt,
  output logic        busy,
  output logic        done
);
  localparam int HALF = (M / 2 < 1) ? 1 : M / 2;
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HALF - 1);
  localparam logic [5:0] LAST_BIT = 6'(DATA_LENG - 1);
  localparam logic [11:0] TIMES = 12'(DATA_TIMES);
  typedef enum logic [2:0] {IDLE, SYNC, SHIFT, WORD, ACK} state_t;
  state_t state, state_nx;
  logic sdi_m, sdi_s, tc, rise_tick, last_bit, last_word, finish;
  logic [CW-1:0] cnt;
  logic [5:0] bit_cnt;
  logic [DATA_LENG-1:0] sr, sr_nx;
  assign tc = busy && cnt == CNT_MAX;
  assign rise_tick = tc && !corr_sclk;
  assign last_bit = bit_cnt == LAST_BIT;
  assign last_word = frame_cnt == TIMES;
  assign finish = state == WORD && last_word;
  assign sr_nx = (sr >> 1) | (DATA_LENG'(sdi_s) << (DATA_LENG - 1));
  always_ff @(posedge clki or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // the completion step folds into WORD so start is accepted right after done rises
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? SYNC : IDLE;
      SYNC:    state_nx = rise_tick ? SHIFT : SYNC;
      SHIFT:   state_nx = (rise_tick && last_bit) ? WORD : SHIFT;
      WORD:    state_nx = last_word ? IDLE : ACK;
      ACK:     state_nx = rise_tick ? SHIFT : ACK;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clki or negedge rst_n)
    if (!rst_n) begin
      sdi_m      <= 1'b0;
      sdi_s      <= 1'b0;
      cnt        <= '0;
      corr_sclk  <= 1'b0;
      rx_ack     <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bit_cnt    <= '0;
      sr         <= '0;
    end else begin
      sdi_m      <= corr_sdi;
      sdi_s      <= sdi_m;
      word_valid <= 1'b0;
      cnt        <= (!busy || finish || tc) ? '0 : cnt + CW'(1);
      corr_sclk  <= (!busy || finish) ? 1'b0 : corr_sclk ^ tc;
      if (state == IDLE && start) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        frame_cnt <= '0;
      end
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if ((state == SYNC || state == ACK) && rise_tick) bit_cnt <= '0;
      // ack drops on the first SHIFT cycle, after the discarded restart tick
      if (state == SHIFT) rx_ack <= 1'b0;
      if (state == SHIFT && rise_tick) begin
        sr      <= sr_nx;
        bit_cnt <= bit_cnt + 6'd1;
        if (last_bit) begin
          word_out   <= 32'(sr_nx);
          word_valid <= 1'b1;
          frame_cnt  <= frame_cnt + 12'd1;
          rx_ack     <= frame_cnt + 12'd1 != TIMES;
        end
      end
    end
endmodule

// File: doc/corr_data_rx.md
# corr_data_rx

Serial capture block for the correlator test path. It drives the divided serial clock, samples the correlator's serial data line LSB first, and assembles `DATA_LENG`-bit words. After each word it issues the end-of-word acknowledge that restarts the correlator's transmitter, and it stops after `DATA_TIMES` words. It sits between the correlator serial interface and the host-side register/readout logic, all in the `clki` domain.

## Interface
- `M`, 166667, divider ratio; one serial bit period = 2*(M/2) `clki` cycles
- `DATA_LENG`, 32, bits per word (1..32)
- `DATA_TIMES`, 2, words captured per run (1..4095)
- `clki`  in  1  system clock (100 MHz)
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse to begin a run; ignored while `busy`=1
- `corr_sdi`  in  1  serial data from the correlator; changes after falling `corr_sclk`
- `corr_sclk`  out  1  divided serial clock to the correlator
- `rx_ack`  out  1  end-of-word acknowledge to the correlator transmitter
- `word_out`  out  32  last captured word, LSB = first bit received, bits above `DATA_LENG-1` are 0
- `word_valid`  out  1  one-cycle pulse when `word_out` updates
- `frame_cnt`  out  12  words captured in the current run
- `busy`  out  1  run in progress
- `done`  out  1  run complete; held until the next accepted `start`

## Operation
- **Input sync.** `corr_sdi` passes through a 2-flop synchronizer, giving `sdi_s`. All sampling uses `sdi_s`.
- **Divider.**
  - Half-period counter `cnt` counts 0..M/2-1 and runs only while `busy`=1.
  - At the terminal count, `corr_sclk` toggles and `cnt` returns to 0.
  - `rise_tick` = terminal count while `corr_sclk`=0.
  - When not busy, `cnt`=0 and `corr_sclk`=0.
- **States:**
  - **IDLE**
    - `start` sets `busy`=1, clears `done` and `frame_cnt`, and goes to SYNC.
  - **SYNC** (`rx_ack`=0)
    - The first `rise_tick` is discarded, because the transmitter has not yet output bit 0.
    - On that tick: clear `bit_cnt` and go to SHIFT.
  - **SHIFT**
    - On each `rise_tick`: shift `sdi_s` into the shift register LSB first (new bit enters at position `DATA_LENG-1`, register shifts right), then `bit_cnt`++.
    - When the sampled bit is bit `DATA_LENG-1`: go to WORD.
  - **WORD** (one `clki` cycle)
    - `word_out` <= assembled word.
    - `word_valid`=1.
    - `frame_cnt`++.
    - If the new count equals `DATA_TIMES`: go to DONE. Otherwise: `rx_ack`<=1 and go to ACK.
  - **ACK**
    - `rx_ack` is held high across the next falling `corr_sclk`, so the transmitter sees it on its negedge and restarts.
    - On the next `rise_tick`: `rx_ack`<=0, the tick is discarded, clear `bit_cnt`, and go to SHIFT.
  - **DONE**
    - `busy`<=0 and `done`<=1; `corr_sclk` is forced low and `cnt` cleared.
    - Return to IDLE in the same cycle, so `start` is accepted on the next cycle.
- **Boundary conditions.**
  - `start` while `busy`=1 is ignored, with no state change.
  - `frame_cnt` never exceeds `DATA_TIMES`; no wrap occurs.
  - `bit_cnt` is 6 bits and compares against `DATA_LENG-1`.
  - `rst_n` low at any point, mid-word or in ACK, immediately returns all state to IDLE values. A partial word is discarded and no `word_valid` is issued.

## Timing
- **Reset values:** `corr_sclk`=0, `rx_ack`=0, `word_out`=0, `word_valid`=0, `frame_cnt`=0, `busy`=0, `done`=0.
- `busy` rises one cycle after `start`.
- The first `corr_sclk` rise is M/2 cycles after `busy` rises; rises then repeat every 2*(M/2) cycles.
- Bit k of word n is sampled on rise (2 + k) + n*(DATA_LENG+1), counting rises from 1.
- `word_valid` and the new `word_out`/`frame_cnt` appear one `clki` cycle after the `rise_tick` that samples the last bit.
- `rx_ack` rises together with `word_valid` and falls on the next `rise_tick`, so it is high for 2*(M/2)+1 cycles.
- `done` rises and `busy` falls one cycle after the final `word_valid`.
- Sampling latency: the `corr_sdi` value must be stable 2 `clki` cycles before the `rise_tick`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run → all outputs equal the reset values within the same cycle; `corr_sclk` stays 0 with no `start`.
- **Divider, single word:** M=4, DATA_TIMES=1, a transmitter model loaded with 0xA5A51234 → first `corr_sclk` rise 2 cycles after `busy`, period 4 cycles. One `word_valid` with `word_out`=0xA5A51234, `frame_cnt`=1, `done`=1, `rx_ack` never high.
- **Two words:** M=4, DATA_TIMES=2, words 0x00000001 then 0x80000000 → one `rx_ack` pulse of 5 cycles spanning one falling `corr_sclk`. Two `word_valid` pulses with the correct values; `frame_cnt`=2, then `done`.
- **Short word:** DATA_LENG=8, word 0x3C → `word_out`=0x0000003C, with `word_valid` 9 `corr_sclk` rises after `start` (first rise discarded).
- **Start while busy:** pulse `start` mid-SHIFT → no restart, `frame_cnt` unaffected, captured word correct.
- **Reset then restart:** `rst_n` pulse during bit 10 of word 0, then `start` → no `word_valid` from the aborted word; the fresh run captures 0xDEADBEEF correctly.
